// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID pipeline register.
// Redirects flush IF/ID (no delay slot); a misaligned redirect target raises a one-cycle addr_err.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_sel,
   input  logic [31:0] branch_base_plus4,
   input  logic [15:0] branch_offset,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        addr_err
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        addr_err_q, addr_err_d;

   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] raw_target;
   logic        redirect_take;

   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = branch_base_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
   // Select 11 is reserved and behaves as if no redirect were requested.
   assign redirect_take = redirect_valid && (redirect_sel != 2'b11);

   always_comb begin
      raw_target = branch_target;
      unique case (redirect_sel)
         2'b00:   raw_target = branch_target;
         2'b01:   raw_target = jump_target;
         2'b10:   raw_target = jr_target;
         default: raw_target = branch_target;
      endcase
   end

   always_comb begin
      pc_d             = pc_q;
      if_id_instr_d    = if_id_instr_q;
      if_id_pc_plus4_d = if_id_pc_plus4_q;
      if_id_valid_d    = if_id_valid_q;
      addr_err_d       = 1'b0;
      if (stall) begin
         // Hold everything; the ID-stage redirect decision is not yet trustworthy.
      end else if (redirect_take) begin
         pc_d             = {raw_target[31:2], 2'b00};
         if_id_instr_d    = 32'd0;
         if_id_pc_plus4_d = 32'd0;
         if_id_valid_d    = 1'b0;
         addr_err_d       = |raw_target[1:0];
      end else begin
         pc_d             = pc_plus4;
         if_id_instr_d    = imem_rdata;
         if_id_pc_plus4_d = pc_plus4;
         if_id_valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q             <= RESET_PC;
         if_id_instr_q    <= 32'd0;
         if_id_pc_plus4_q <= 32'd0;
         if_id_valid_q    <= 1'b0;
         addr_err_q       <= 1'b0;
      end else begin
         pc_q             <= pc_d;
         if_id_instr_q    <= if_id_instr_d;
         if_id_pc_plus4_q <= if_id_pc_plus4_d;
         if_id_valid_q    <= if_id_valid_d;
         addr_err_q       <= addr_err_d;
      end
   end

   assign imem_addr      = pc_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc_plus4 = if_id_pc_plus4_q;
   assign if_id_valid    = if_id_valid_q;
   assign addr_err       = addr_err_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the single-issue MIPS pipeline.
- Holds the program counter and drives the instruction-memory address; imem is combinational read.
- Selects next PC from four sources: sequential PC+4, branch target, jump target, jr register.
- The jump target arrives already formed as {PC+4[31:28], instr_index, 2'b00} by the jump-combine stage fed from this block's if_id_pc_plus4; output is the IF/ID pipeline register with stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  input  1  ID stage resolved a taken control transfer this cycle.
- redirect_sel  input  2  00 branch, 01 jump, 10 jr, 11 reserved.
- branch_base_plus4  input  32  PC+4 of the branch instruction in ID.
- branch_offset  input  16  branch immediate, signed word offset.
- jump_target  input  32  full jump address from the jump-combine stage.
- jr_target  input  32  rs register value for jr.
- imem_addr  output  32  current PC, to instruction memory.
- imem_rdata  input  32  instruction at imem_addr, same cycle.
- if_id_instr  output  32  registered instruction.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
- addr_err  output  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Reset (synchronous, highest priority)
  - PC=RESET_PC; if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, addr_err=0.
  - Reset overrides stall and redirect. Asserting reset mid-stream discards the IF/ID contents at that edge.
- Datapath
  - imem_addr = PC, combinational from the PC register.
  - pc_plus4 = PC + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Branch target
  - branch_base_plus4 + ({{14{off[15]}}, off, 2'b00}), 32-bit wrap, carry discarded.
- Next-PC priority (rising edge, reset low)
  - 1) stall=1: PC, if_id_* all hold. Redirect is ignored because the ID decision is not yet valid; addr_err=0.
  - 2) redirect_valid=1 and redirect_sel in {00,01,10}: PC = selected target with bits [1:0] forced to 00. IF/ID flushed: if_id_instr=0 (NOP), if_id_valid=0, if_id_pc_plus4=0. No delay slot.
  - 3) Otherwise: PC = pc_plus4; if_id_instr = imem_rdata; if_id_pc_plus4 = pc_plus4; if_id_valid = 1.
  - redirect_sel=11 with redirect_valid=1 is treated as no redirect (case 3).
- Alignment
  - addr_err=1 for exactly the cycle after an accepted redirect whose raw target[1:0] != 00; otherwise 0. Registered.
  - The jump path is always aligned by construction. Jr and branch paths are checked on the same rule.
- Latency
  - One cycle from imem_addr to IF/ID. A taken redirect costs one bubble; the first target instruction is valid in IF/ID two edges after redirect_valid.
- Stall release
  - Resumes with the held PC: no instruction is lost or duplicated.

Test Plan:
1. Reset, RESET_PC=0x0040_0000, release, imem returns 0x2008_0005 -> cycle 0 imem_addr=0x0040_0000; after edge if_id_instr=0x2008_0005, if_id_pc_plus4=0x0040_0004, valid=1, imem_addr=0x0040_0004.
2. Branch: base_plus4=0x0040_0010, offset=16'hFFFC, sel=00 -> next PC=0x0040_0000; IF/ID bubble (instr=0, valid=0); following edge valid=1 with pc_plus4=0x0040_0004.
3. Jump: jump_target=0x0040_0100, sel=01 held 1 cycle -> PC=0x0040_0100, one bubble. Jr: jr_target=0x1000_0002, sel=10 -> PC=0x1000_0000, addr_err=1 for one cycle then 0.
4. Stall 3 cycles at PC=0x0040_0008 with redirect_valid=1 concurrently -> PC and IF/ID unchanged all 3 cycles, no redirect, addr_err=0; on release, fetch continues from 0x0040_0008.
5. PC=0xFFFF_FFFC sequential -> if_id_pc_plus4=0x0000_0000, PC wraps to 0. Branch base_plus4=0x0000_0004, offset=16'h8000 -> target 0xFFFE_0004.
6. Reset asserted during a stall and redirect in the same cycle -> PC=RESET_PC, valid=0, addr_err=0 at that edge. redirect_sel=11 -> sequential fetch, no flush.
